// File: rtl/muldiv_pkg.sv
// Shared encodings and default latencies for the HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Only the four arithmetic ops may be issued with start.
   function automatic logic is_arith_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/muldiv.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed at issue; the counter only models the latency.
module muldiv
   import muldiv_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic        we,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   state_e             state;
   logic [CNT_W-1:0]   cnt;
   logic [31:0]        hi_tmp;
   logic [31:0]        lo_tmp;

   logic signed [63:0] a_s;
   logic signed [63:0] b_s;
   logic signed [63:0] div_s;
   logic        [63:0] a_u;
   logic        [63:0] b_u;
   logic        [63:0] div_u;
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic        [31:0] quot_s;
   logic        [31:0] rem_s;
   logic        [31:0] quot_u;
   logic        [31:0] rem_u;
   logic        [31:0] res_hi;
   logic        [31:0] res_lo;

   // Signed division runs at 64 bits so 0x80000000 / -1 cannot overflow; a
   // zero divisor is replaced by 1 and its result discarded in favour of HI/LO.
   always_comb begin
      a_s    = {{32{A[31]}}, A};
      b_s    = {{32{B[31]}}, B};
      a_u    = {32'd0, A};
      b_u    = {32'd0, B};
      div_s  = (B == 32'd0) ? 64'sd1 : b_s;
      div_u  = (B == 32'd0) ? 64'd1 : b_u;
      prod_s = a_s * b_s;
      prod_u = a_u * b_u;
      quot_s = 32'(a_s / div_s);
      rem_s  = 32'(a_s % div_s);
      quot_u = 32'(a_u / div_u);
      rem_u  = 32'(a_u % div_u);
      res_hi = HI;
      res_lo = LO;
      case (md_op)
         MD_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         MD_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         MD_DIV: begin
            if (B != 32'd0) begin
               res_hi = rem_s;
               res_lo = quot_s;
            end
         end
         MD_DIVU: begin
            if (B != 32'd0) begin
               res_hi = rem_u;
               res_lo = quot_u;
            end
         end
         default: begin
         end
      endcase
   end

   // HI/LO only change on completion of an op or on an idle MTHI/MTLO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         hi_tmp <= '0;
         lo_tmp <= '0;
         busy   <= 1'b0;
         HI     <= '0;
         LO     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && is_arith_op(md_op)) begin
                  hi_tmp <= res_hi;
                  lo_tmp <= res_lo;
                  cnt    <= is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                  busy   <= 1'b1;
                  state  <= RUN;
               end else if (we && !start) begin
                  if (md_op == MD_MTHI) begin
                     HI <= A;
                  end else if (md_op == MD_MTLO) begin
                     LO <= A;
                  end
               end
            end
            RUN: begin
               if (cnt <= CNT_W'(1)) begin
                  HI    <= hi_tmp;
                  LO    <= lo_tmp;
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed corner cases followed by random
// traffic, all compared against an arithmetic HI/LO model.
module tb_muldiv;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic        we;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] model_hi   = 32'd0;
   logic [31:0] model_lo   = 32'd0;

   muldiv #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .we    (we),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   always #5 clk = ~clk;

   // Reference result {HI,LO} from the architectural definitions; a zero
   // divisor yields the previous HI/LO.
   function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] prev);
      longint          sa, sb, ma, mb, q, r;
      longint unsigned ua, ub, uq, ur;
      logic [63:0]     ret;
      ret = prev;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      case (op)
         OP_MULT:  begin q = sa * sb; ret = q; end
         OP_MULTU: begin uq = ua * ub; ret = uq; end
         OP_DIV: begin
            if (b != 32'd0) begin
               ma  = (sa < 0) ? -sa : sa;
               mb  = (sb < 0) ? -sb : sb;
               q   = ma / mb;
               if ((sa < 0) != (sb < 0)) q = -q;
               r   = sa - q * sb;
               ret = {r[31:0], q[31:0]};
            end
         end
         OP_DIVU: begin
            if (b != 32'd0) begin
               uq  = ua / ub;
               ur  = ua - uq * ub;
               ret = {ur[31:0], uq[31:0]};
            end
         end
         default: ret = prev;
      endcase
      return ret;
   endfunction

   task automatic applyStimulus(input logic s, input logic [2:0] op, input logic w,
                                input logic [31:0] a, input logic [31:0] b);
      start = s;
      md_op = op;
      we    = w;
      A     = a;
      B     = b;
   endtask

   task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic exp_busy);
      checkValue({tag, "/busy"}, {31'd0, busy}, {31'd0, exp_busy});
      checkValue({tag, "/HI"}, HI, model_hi);
      checkValue({tag, "/LO"}, LO, model_lo);
   endtask

   // Issue one md op; disturb=1 injects an MTLO mid-run, disturb=2 a second start.
   task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int disturb);
      int          n;
      int          cycles;
      logic [63:0] res;
      n   = (op == OP_DIV || op == OP_DIVU) ? DIV_N : MULT_N;
      res = refResult(op, a, b, {model_hi, model_lo});
      @(negedge clk);
      applyStimulus(1'b1, op, 1'b0, a, b);
      @(negedge clk);
      applyStimulus(1'b0, 3'd0, 1'b0, $urandom, $urandom);
      cycles = 0;
      while (busy === 1'b1 && cycles < n + 4) begin
         cycles++;
         checkValue({tag, "/holdHI"}, HI, model_hi);
         checkValue({tag, "/holdLO"}, LO, model_lo);
         if (cycles == 2 && disturb == 1)
            applyStimulus(1'b0, OP_MTLO, 1'b1, $urandom, $urandom);
         else if (cycles == 2 && disturb == 2)
            applyStimulus(1'b1, 3'($urandom_range(0, 3)), 1'b0, $urandom, $urandom);
         else
            applyStimulus(1'b0, 3'd0, 1'b0, $urandom, $urandom);
         @(negedge clk);
      end
      applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
      checkValue({tag, "/busyCycles"}, 32'(cycles), 32'(n));
      model_hi = res[63:32];
      model_lo = res[31:0];
      checkOutput({tag, "/done"}, 1'b0);
   endtask

   task automatic doMt(input string tag, input logic [2:0] op, input logic [31:0] a);
      @(negedge clk);
      applyStimulus(1'b0, op, 1'b1, a, $urandom);
      @(negedge clk);
      applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
      if (op == OP_MTHI) model_hi = a;
      else if (op == OP_MTLO) model_lo = a;
      checkOutput(tag, 1'b0);
   endtask

   task automatic doReservedStart(input string tag, input logic [2:0] op);
      @(negedge clk);
      applyStimulus(1'b1, op, 1'b1, $urandom, $urandom);
      @(negedge clk);
      applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
      checkOutput(tag, 1'b0);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] ra;
      logic [31:0] rb;
      int          pick;

      reset = 1'b1;
      applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("reset", 1'b0);
      reset = 1'b0;

      // Asynchronous reset in the middle of a multiply.
      doMt("preHI", OP_MTHI, 32'h0000_1234);
      doMt("preLO", OP_MTLO, 32'h0000_5678);
      @(negedge clk);
      applyStimulus(1'b1, OP_MULT, 1'b0, 32'd3, 32'd5);
      @(negedge clk);
      applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      #2 reset = 1'b1;
      #1 model_hi = 32'd0;
      model_lo = 32'd0;
      checkOutput("rstMid", 1'b0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      checkOutput("rstAfter", 1'b0);

      runOp("multNeg", OP_MULT, 32'hFFFF_FFFF, 32'd2, 0);
      checkValue("multNeg/HIconst", HI, 32'hFFFF_FFFF);
      checkValue("multNeg/LOconst", LO, 32'hFFFF_FFFE);
      runOp("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
      checkValue("multu/HIconst", HI, 32'h0000_0001);
      checkValue("multu/LOconst", LO, 32'hFFFF_FFFE);
      runOp("divNeg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
      checkValue("divNeg/LOconst", LO, 32'hFFFF_FFFD);
      checkValue("divNeg/HIconst", HI, 32'hFFFF_FFFF);
      runOp("divu", OP_DIVU, 32'd7, 32'd2, 0);
      checkValue("divu/LOconst", LO, 32'd3);
      checkValue("divu/HIconst", HI, 32'd1);
      runOp("divOvf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      checkValue("divOvf/LOconst", LO, 32'h8000_0000);
      checkValue("divOvf/HIconst", HI, 32'd0);

      doMt("mthi11", OP_MTHI, 32'h0000_0011);
      doMt("mtlo22", OP_MTLO, 32'h0000_0022);
      runOp("divuZero", OP_DIVU, 32'd5, 32'd0, 0);
      checkValue("divuZero/HIconst", HI, 32'h0000_0011);
      checkValue("divuZero/LOconst", LO, 32'h0000_0022);
      runOp("divZero", OP_DIV, 32'hFFFF_0000, 32'd0, 0);

      doMt("mthiBeef", OP_MTHI, 32'hDEAD_BEEF);
      runOp("multMtlo", OP_MULT, 32'd1234, 32'd5678, 1);
      runOp("multRestart", OP_MULT, 32'h0001_0000, 32'h0001_0000, 2);
      runOp("divRestart", OP_DIV, 32'd100, 32'hFFFF_FFFD, 2);
      doReservedStart("rsvdStart6", 3'd6);
      doMt("rsvdWe7", 3'd7, 32'hCAFE_F00D);

      for (int i = 0; i < 40; i++) begin
         pick = int'($urandom_range(0, 9));
         ra   = $urandom;
         rb   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if (pick <= 5) begin
            op = 3'($urandom_range(0, 3));
            runOp("rndOp", op, ra, rb, int'($urandom_range(0, 2)));
         end else if (pick <= 7) begin
            doMt("rndMt", (pick == 6) ? OP_MTHI : OP_MTLO, ra);
         end else if (pick == 8) begin
            doReservedStart("rndRsvd", 3'($urandom_range(6, 7)));
         end else begin
            doMt("rndRsvdWe", 3'($urandom_range(6, 7)), ra);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
